// File: rtl/trng_fetch.sv
// TRNG consumer: drives gen/rdy/rdn request handshake, buffers words in a show-ahead FIFO,
// request watchdog. Optional repetition health test enabled by `define TRNG_FETCH_RCT_EN.
module trng_fetch #(
    parameter int W     = 32,
    parameter int DEPTH = 4,
    parameter int TMO   = 4096
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     clr,
    output logic                     gen,
    input  logic                     rdy,
    input  logic [W-1:0]             rdn,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [W-1:0]             rd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     tmo_err,
    output logic                     alarm
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int CW = $clog2(TMO);
    localparam logic [CW-1:0] WD_MAX = CW'(TMO - 1);
    localparam logic [CW-1:0] WD_PRE = CW'(TMO - 2);

    typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    mem_q [DEPTH];
    logic [PW-1:0]   wptr_q, rptr_q;
    logic [LW-1:0]   level_q, level_d, lvl_after_pop;
    logic [CW-1:0]   wd_q, wd_d;
    logic            tmo_q, tmo_d;
    logic            capture, push, pop, rct_hit, wd_hit;

    assign gen           = (state_q == REQ);
    assign capture       = rdy && gen;
    assign rd_valid      = (level_q != '0);
    assign pop           = rd_valid && rd_ready;
    assign push          = capture && !rct_hit;
    assign rd_data       = rd_valid ? mem_q[rptr_q] : '0;
    assign level         = level_q;
    assign tmo_err       = tmo_q;
    assign lvl_after_pop = level_q - LW'(pop);

    // Request decision looks at occupancy after this cycle's pop so a full FIFO
    // being drained re-requests without an extra bubble.
    always_comb begin
        state_d = state_q;
        wd_d    = wd_q;
        wd_hit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (en && (lvl_after_pop < LW'(DEPTH))) begin
                    state_d = REQ;
                    wd_d    = '0;
                end
            end
            REQ: begin
                if (rdy) begin
                    state_d = IDLE;
                end else begin
                    if (!en) state_d = IDLE;
                    if (wd_q != WD_MAX) begin
                        wd_d   = wd_q + 1'b1;
                        wd_hit = (wd_q == WD_PRE);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign level_d = level_q + LW'(push) - LW'(pop);
    assign tmo_d   = wd_hit | (tmo_q & ~clr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            wd_q    <= '0;
            tmo_q   <= 1'b0;
            level_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            tmo_q   <= tmo_d;
            level_q <= level_d;
            if (push) begin
                mem_q[wptr_q] <= rdn;
                wptr_q        <= wptr_q + 1'b1;
            end
            if (pop) rptr_q <= rptr_q + 1'b1;
        end
    end

`ifdef TRNG_FETCH_RCT_EN
    logic [W-1:0] last_q;
    logic         last_vld_q;
    logic         alarm_q;

    // Every capture updates the reference, including rejected repeats.
    assign rct_hit = capture && last_vld_q && (rdn == last_q);
    assign alarm   = alarm_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q     <= '0;
            last_vld_q <= 1'b0;
            alarm_q    <= 1'b0;
        end else begin
            if (capture) begin
                last_q     <= rdn;
                last_vld_q <= 1'b1;
            end
            alarm_q <= rct_hit | (alarm_q & ~clr);
        end
    end
`else
    assign rct_hit = 1'b0;
    assign alarm   = 1'b0;
`endif

endmodule
